acc_serial_tx: RTL
==================

# acc_serial_tx

Serial output port for the 8-bit CPU datapath. On an OUT request it captures the current accumulator value and shifts it out on a single wire as an asynchronous frame: start bit, 8 data bits LSB first, optional even parity, stop bit(s). It sits on the accumulator's read side, opposite the ALU/control path that writes the accumulator, and gives the CPU a visible serial output.

## Interface
Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit; legal range 2..65535.
- STOP_BITS, default 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- out_req  input  1  request to transmit `in`; honoured only while `ready` is 1.
- in  input  8  accumulator value, wired to the accumulator output.
- ready  output  1  high in IDLE; request accepted on a posedge where out_req && ready.
- busy  output  1  high from the accept edge until the frame ends.
- done  output  1  one-cycle pulse after the last stop bit completes.
- tx  output  1  serial line; idle level 1.

## Operation
- Reset values: tx=1, ready=1, busy=0, done=0, state IDLE, bit and baud counters 0.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE: tx=1. On accept, load `in` into the shift register and enter START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx=shift[0]; shift right every CLKS_PER_BIT cycles. After 8 bits, go to PARITY if enabled, otherwise STOP.
- PARITY: tx = XOR of the 8 captured bits (even parity) for one bit time, then STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. Then return to IDLE and pulse done.
- The data byte is captured only at the accept edge. Later changes on `in` do not affect the frame in flight.
- Requests while busy are ignored; there is no queue. The requester must wait for ready.
- The baud counter is width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and wraps. A bit ends on the wrap cycle.
- The bit counter is 3 bits. DATA exits when the counter is 7 and the baud counter wraps.

## Timing
- The accumulator updates on negedge. `in` is therefore stable at the posedge where this block samples it; no extra synchronisation is needed.
- All outputs are registered; tx is glitch-free.
- Accept edge at posedge N:
  - tx=0 and busy=1 from N.
  - The start bit covers cycles N..N+CLKS_PER_BIT-1.
- Frame length F = (1 + 8 + P + STOP_BITS) * CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- At posedge N+F: state is IDLE, done=1 for one cycle, ready=1, busy=0.
- Back-to-back: a request high during the done cycle is accepted at the next posedge.
  - One idle bit-time is not inserted.
  - Minimum spacing between starts is F+1 cycles.
- Reset asserted mid-frame: tx=1, outputs return to reset values immediately, the frame is abandoned and done does not pulse. After release, the first posedge is in IDLE.
- out_req on the same edge that reset deasserts is ignored.

## Configuration
- ACC_TX_PARITY_EN defined: the PARITY state is compiled in, P=1, and one even-parity bit is sent after the data bits.
- Undefined: the PARITY state and its XOR logic are absent, P=0, and DATA goes directly to STOP.

## Structure
- Shared package `cpu_io_pkg`:
  - state enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - constant `TX_DATA_W = 8`;
  - the idle-line-level constant.
- Sub-module `baud_tick_gen`, parameter CLKS_PER_BIT:
  - inputs clk, rst and an enable (high outside IDLE);
  - output is a one-cycle `tick` on counter wrap;
  - the counter clears when enable is low, so every bit starts phase-aligned with the accept edge.

## Test plan
- Reset then idle: hold rst=1 for 3 cycles, release, run 50 cycles with no request -> tx=1, ready=1, busy=0, done=0 throughout.
- Basic frame, CLKS_PER_BIT=4, no parity: accept with in=0xA5 -> tx per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. done pulses exactly 40 cycles after the accept edge.
- Data capture and ignored request: change in to 0xFF and pulse out_req during the frame -> the line still carries 0xA5 and the second request is ignored. In a separate run, request during the done cycle -> the second frame starts on the next edge.
- Parity build, CLKS_PER_BIT=4: send 0xA5 -> parity bit 0. Send 0x07 -> parity bit 1. Frame is 44 cycles.
- STOP_BITS=2, CLKS_PER_BIT=4: send 0x00 -> data bits all 0, tx=1 for 8 cycles at the end, done at cycle 44 with no parity.
- Reset mid-frame: assert rst during data bit 3 -> tx=1 and busy=0 immediately, no done pulse. A new request after release sends a complete, correct frame.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU serial I/O blocks: frame state encoding,
// data width and the idle level of the serial line.
package cpu_io_pkg;

    localparam int   TX_DATA_W     = 8;
    localparam logic TX_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-time generator: one-cycle tick every CLKS_PER_BIT enabled cycles.
// The counter is held at zero while disabled so each frame starts phase-aligned.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/acc_serial_tx.sv
// Accumulator serial output port: start bit, 8 data bits LSB first, optional
// even parity (compiled in with ACC_TX_PARITY_EN), STOP_BITS stop bits.
module acc_serial_tx
    import cpu_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 out_req,
    input  logic [TX_DATA_W-1:0] in,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic                 tx,
    output tx_state_t            state
);

    // Handshake: a frame is accepted on any posedge where out_req && ready;
    // ready stays low until the posedge that pulses done, requests meanwhile are dropped.

    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    logic [TX_DATA_W-1:0] shift;
    logic [2:0]           bitcnt;
    logic                 tick;
    logic                 baud_en;
`ifdef ACC_TX_PARITY_EN
    logic                 par;
`endif

    assign baud_en = (state != IDLE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (baud_en),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shift  <= '0;
            bitcnt <= '0;
            tx     <= TX_IDLE_LEVEL;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef ACC_TX_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (out_req && ready) begin
                        shift  <= in;
`ifdef ACC_TX_PARITY_EN
                        par    <= ^in;
`endif
                        bitcnt <= '0;
                        state  <= START;
                        tx     <= 1'b0;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        tx    <= shift[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bitcnt == 3'd7) begin
                            bitcnt <= '0;
`ifdef ACC_TX_PARITY_EN
                            state  <= PARITY;
                            tx     <= par;
`else
                            state  <= STOP;
                            tx     <= TX_IDLE_LEVEL;
`endif
                        end else begin
                            bitcnt <= bitcnt + 3'd1;
                            shift  <= {1'b0, shift[TX_DATA_W-1:1]};
                            tx     <= shift[1];
                        end
                    end
                end
`ifdef ACC_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        tx    <= TX_IDLE_LEVEL;
                    end
                end
`endif
                STOP: begin
                    // bitcnt is reused to count stop bits
                    if (tick) begin
                        if (bitcnt == LAST_STOP) begin
                            bitcnt <= '0;
                            state  <= IDLE;
                            ready  <= 1'b1;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            bitcnt <= bitcnt + 3'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= TX_IDLE_LEVEL;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
